kinase_valve_sequencer: RTL and testbench
=========================================

KINASE_VALVE_SEQUENCER -- requirements
Module: kinase_valve_sequencer

Interface
REQ-001 Parameter DWELL_W, default 16; width of the dwell counter and cmd_dwell.
REQ-002 Parameter SETTLE_CYC, default 8; valve settle time in cycles, legal range 1..255.
REQ-003 Parameter PUMP_DIV, default 4; cycles per pump phase, legal range 1..255.
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 cmd_valid  input  1  step command offered.
REQ-007 cmd_ready  output  1  sequencer accepts a step.
REQ-008 cmd_valves  input  13  requested ctrl_a valve pattern.
REQ-009 cmd_sel  input  4  requested ctrl_s selector pattern.
REQ-010 cmd_pump_en  input  2  bit0 enables pump_a, bit1 enables pump_b.
REQ-011 cmd_dwell  input  DWELL_W  pumping duration in cycles.
REQ-012 abort  input  1  terminate the current step.
REQ-013 ctrl_a  output  13  valve drive, aligned to pad_ctrl_a.
REQ-014 ctrl_s  output  4  selector drive, aligned to pad_ctrl_s.
REQ-015 pump_a  output  3  three-valve peristaltic drive, aligned to pad_pump_a.
REQ-016 pump_b  output  2  two-valve pump drive, aligned to pad_pump_b.
REQ-017 busy  output  1  high in any state other than IDLE.
REQ-018 done  output  1  one-cycle pulse on step completion.

Function
REQ-019 The FSM SHALL have the states IDLE, SETTLE, RUN and FINISH.
REQ-020 cmd_ready SHALL equal (state==IDLE); a step is accepted when cmd_valid&&cmd_ready, and the command fields are registered on that edge.
REQ-021 On acceptance: IDLE->SETTLE; ctrl_a/ctrl_s take the new patterns on the next cycle; pumps 0; settle counter loaded with SETTLE_CYC-1.
REQ-022 SETTLE SHALL last exactly SETTLE_CYC cycles, then go to RUN if cmd_dwell!=0, otherwise go to FINISH.
REQ-023 RUN SHALL last exactly cmd_dwell cycles (dwell counter counts down to 0, no wrap), then go to FINISH.
REQ-024 In RUN with pump_a enabled, pump_a SHALL cycle 3'b110 -> 3'b011 -> 3'b101 -> 3'b110, advancing every PUMP_DIV cycles and starting at 3'b110 on RUN entry.
REQ-025 In RUN with pump_b enabled, pump_b SHALL alternate 2'b10 / 2'b01, advancing every PUMP_DIV cycles and starting at 2'b10.
REQ-026 A disabled pump, and both pumps outside RUN, SHALL output all zeros; phase and divider counters SHALL restart on every RUN entry.
REQ-027 FINISH SHALL last one cycle with done=1 and pumps 0, then return to IDLE.
REQ-028 ctrl_a/ctrl_s SHALL hold the last step's pattern through IDLE until the next acceptance.
REQ-029 abort SHALL take priority over all transitions. In any non-IDLE state the next cycle is IDLE with ctrl_a=0, ctrl_s=0, pumps 0 and no done pulse.
REQ-030 abort in IDLE SHALL clear ctrl_a/ctrl_s and block acceptance in that cycle.
REQ-031 cmd_valid outside IDLE SHALL be ignored; there is no queueing.
REQ-032 Overall latency SHALL be: acceptance edge to done pulse = SETTLE_CYC + cmd_dwell + 1 cycles.

Reset
REQ-033 With rst_n=0 at a clock edge: state IDLE, ctrl_a=0, ctrl_s=0, pump_a=0, pump_b=0, busy=0, done=0, all counters 0.
REQ-034 Reset asserted mid-step SHALL abandon the step and produce no done pulse.
REQ-035 cmd_ready SHALL be 0 while rst_n=0 and 1 on the first cycle after release.

Verification
REQ-036 Test normal step. Stimulus: defaults; accept valves=13'h1A5, sel=4'h3, pump_en=2'b01, dwell=12. Response: ctrl_a=13'h1A5 from the next cycle; pump_a=110 for 4 cycles, 011 for 4, 101 for 4; done 21 cycles after acceptance; ctrl_a still 13'h1A5 afterwards.
REQ-037 Test zero dwell. Stimulus: dwell=0, pump_en=2'b11. Response: pumps never nonzero; done 9 cycles after acceptance.
REQ-038 Test abort. Stimulus: assert abort in the 3rd RUN cycle. Response: next cycle IDLE, all outputs 0, no done, cmd_ready=1.
REQ-039 Test ignored command. Stimulus: cmd_valid held high during a step with different fields. Response: no second acceptance until IDLE; outputs unaffected by the new fields.
REQ-040 Test reset mid-step. Stimulus: rst_n=0 for 1 cycle during SETTLE. Response: all outputs 0 next cycle, done never pulses.
REQ-041 Test pump_b. Stimulus: PUMP_DIV=1, pump_en=2'b10, dwell=5. Response: pump_b sequence 10,01,10,01,10; pump_a=0 throughout.

Source files
------------

// File: rtl/kinase_valve_sequencer.sv
// kinase_valve_sequencer
//   Steps a microfluidic valve array through one command at a time:
//   apply the valve/selector pattern, wait for the valves to settle,
//   run the enabled peristaltic pumps for the requested dwell, then
//   pulse done and return to IDLE.
//
// Parameters
//   DWELL_W    width of cmd_dwell and the dwell counter
//   SETTLE_CYC valve settle time in cycles (1..255)
//   PUMP_DIV   cycles per pump phase (1..255)
//
// Ports
//   clk          single clock, rising edge
//   rst_n        synchronous active-low reset
//   cmd_valid    step command offered
//   cmd_ready    high in IDLE (and out of reset): a step can be accepted
//   cmd_valves   ctrl_a pattern for the step
//   cmd_sel      ctrl_s pattern for the step
//   cmd_pump_en  bit0 enables pump_a, bit1 enables pump_b
//   cmd_dwell    pumping duration in cycles (0 skips RUN)
//   abort        terminate the current step, clear all drives
//   ctrl_a       13-bit valve drive (registered)
//   ctrl_s       4-bit selector drive (registered)
//   pump_a       3-valve peristaltic drive (registered)
//   pump_b       2-valve pump drive (registered)
//   busy         high in any state other than IDLE
//   done         one-cycle pulse on step completion

module kinase_valve_sequencer #(
    parameter int DWELL_W    = 16,
    parameter int SETTLE_CYC = 8,
    parameter int PUMP_DIV   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [12:0]        cmd_valves,
    input  logic [3:0]         cmd_sel,
    input  logic [1:0]         cmd_pump_en,
    input  logic [DWELL_W-1:0] cmd_dwell,
    input  logic               abort,
    output logic [12:0]        ctrl_a,
    output logic [3:0]         ctrl_s,
    output logic [2:0]         pump_a,
    output logic [1:0]         pump_b,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [7:0] SETTLE_M1 = 8'(SETTLE_CYC - 1);
    localparam logic [7:0] PUMP_M1   = 8'(PUMP_DIV - 1);

    state_t             state;
    logic [7:0]         settle_cnt;
    logic [7:0]         div_cnt;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [1:0]         pump_en_q;

    assign cmd_ready = rst_n && (state == IDLE);
    assign busy      = (state != IDLE);

    // The pump output registers double as the phase state: pump_a rotates
    // right (110 -> 011 -> 101) and pump_b swaps its bits, so a disabled
    // pump loaded with zero simply stays at zero while RUN advances.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            ctrl_a     <= '0;
            ctrl_s     <= '0;
            pump_a     <= '0;
            pump_b     <= '0;
            done       <= 1'b0;
            settle_cnt <= '0;
            div_cnt    <= '0;
            dwell_cnt  <= '0;
            pump_en_q  <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state      <= IDLE;
                ctrl_a     <= '0;
                ctrl_s     <= '0;
                pump_a     <= '0;
                pump_b     <= '0;
                settle_cnt <= '0;
                div_cnt    <= '0;
                dwell_cnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (cmd_valid) begin
                            state      <= SETTLE;
                            ctrl_a     <= cmd_valves;
                            ctrl_s     <= cmd_sel;
                            pump_en_q  <= cmd_pump_en;
                            dwell_cnt  <= cmd_dwell;
                            settle_cnt <= SETTLE_M1;
                        end
                    end
                    SETTLE: begin
                        if (settle_cnt == '0) begin
                            if (dwell_cnt != '0) begin
                                // dwell_cnt holds the raw dwell here; reload
                                // as dwell-1 so RUN spans exactly dwell cycles.
                                state     <= RUN;
                                dwell_cnt <= dwell_cnt - DWELL_W'(1);
                                div_cnt   <= PUMP_M1;
                                pump_a    <= pump_en_q[0] ? 3'b110 : 3'b000;
                                pump_b    <= pump_en_q[1] ? 2'b10  : 2'b00;
                            end else begin
                                state <= FINISH;
                                done  <= 1'b1;
                            end
                        end else begin
                            settle_cnt <= settle_cnt - 8'd1;
                        end
                    end
                    RUN: begin
                        if (dwell_cnt == '0) begin
                            state   <= FINISH;
                            done    <= 1'b1;
                            pump_a  <= '0;
                            pump_b  <= '0;
                            div_cnt <= '0;
                        end else begin
                            dwell_cnt <= dwell_cnt - DWELL_W'(1);
                            if (div_cnt == '0) begin
                                div_cnt <= PUMP_M1;
                                pump_a  <= {pump_a[0], pump_a[2:1]};
                                pump_b  <= {pump_b[0], pump_b[1]};
                            end else begin
                                div_cnt <= div_cnt - 8'd1;
                            end
                        end
                    end
                    FINISH: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_kinase_valve_sequencer.sv
// tb_kinase_valve_sequencer
//   Scoreboard bench for kinase_valve_sequencer. Two instances share the
//   stimulus: one with default parameters, one with PUMP_DIV=1. For every
//   step the expected per-cycle outputs of both are computed from the step
//   timeline (settle, dwell, finish) and queued; each falling edge pops one
//   record per instance and compares it with the DUT outputs.

module tb_kinase_valve_sequencer;

    localparam int SETTLE_CYC = 8;
    localparam int PUMP_DIV   = 4;

    typedef struct packed {
        logic [12:0] ctrl_a;
        logic [3:0]  ctrl_s;
        logic [2:0]  pump_a;
        logic [1:0]  pump_b;
        logic        busy;
        logic        done;
        logic        ready;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic [12:0] cmd_valves;
    logic [3:0]  cmd_sel;
    logic [1:0]  cmd_pump_en;
    logic [15:0] cmd_dwell;
    logic        abort;

    logic        ready0, busy0, done0;
    logic [12:0] ctrl_a0;
    logic [3:0]  ctrl_s0;
    logic [2:0]  pump_a0;
    logic [1:0]  pump_b0;

    logic        ready1, busy1, done1;
    logic [12:0] ctrl_a1;
    logic [3:0]  ctrl_s1;
    logic [2:0]  pump_a1;
    logic [1:0]  pump_b1;

    int checks = 0;
    int errors = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    logic [12:0] prev_a;
    logic [3:0]  prev_s;

    always #5 clk = ~clk;

    kinase_valve_sequencer u_dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(ready0),
        .cmd_valves(cmd_valves), .cmd_sel(cmd_sel), .cmd_pump_en(cmd_pump_en),
        .cmd_dwell(cmd_dwell), .abort(abort), .ctrl_a(ctrl_a0), .ctrl_s(ctrl_s0),
        .pump_a(pump_a0), .pump_b(pump_b0), .busy(busy0), .done(done0)
    );

    kinase_valve_sequencer #(.PUMP_DIV(1)) u_dut_div1 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(ready1),
        .cmd_valves(cmd_valves), .cmd_sel(cmd_sel), .cmd_pump_en(cmd_pump_en),
        .cmd_dwell(cmd_dwell), .abort(abort), .ctrl_a(ctrl_a1), .ctrl_s(ctrl_s1),
        .pump_a(pump_a1), .pump_b(pump_b1), .busy(busy1), .done(done1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected outputs k cycles after the acceptance edge (k=0: the cycle
    // in which the command is offered).
    function automatic exp_t exp_at(input int k, input logic [12:0] v, input logic [3:0] s,
                                    input logic [1:0] en, input int d, input int div,
                                    input logic [12:0] pa, input logic [3:0] ps);
        exp_t e;
        int   ph;
        e = '0;
        if (k == 0) begin
            e.ctrl_a = pa;
            e.ctrl_s = ps;
            e.ready  = 1'b1;
        end else begin
            e.ctrl_a = v;
            e.ctrl_s = s;
            e.busy   = 1'b1;
            if (k > SETTLE_CYC && k <= SETTLE_CYC + d) begin
                ph = (k - SETTLE_CYC - 1) / div;
                if (en[0]) begin
                    case (ph % 3)
                        0:       e.pump_a = 3'b110;
                        1:       e.pump_a = 3'b011;
                        default: e.pump_a = 3'b101;
                    endcase
                end
                if (en[1]) e.pump_b = ((ph % 2) == 0) ? 2'b10 : 2'b01;
            end
            if (k == SETTLE_CYC + d + 1) e.done = 1'b1;
        end
        return e;
    endfunction

    function automatic exp_t idle_rec(input logic [12:0] pa, input logic [3:0] ps, input logic rdy);
        exp_t e;
        e        = '0;
        e.ctrl_a = pa;
        e.ctrl_s = ps;
        e.ready  = rdy;
        return e;
    endfunction

    always @(negedge clk) begin
        if (q0.size() > 0) begin
            e0 = q0.pop_front();
            check("ctrl_a",    32'(ctrl_a0), 32'(e0.ctrl_a));
            check("ctrl_s",    32'(ctrl_s0), 32'(e0.ctrl_s));
            check("pump_a",    32'(pump_a0), 32'(e0.pump_a));
            check("pump_b",    32'(pump_b0), 32'(e0.pump_b));
            check("busy",      32'(busy0),   32'(e0.busy));
            check("done",      32'(done0),   32'(e0.done));
            check("cmd_ready", 32'(ready0),  32'(e0.ready));
        end
        if (q1.size() > 0) begin
            e1 = q1.pop_front();
            check("div1_ctrl_a",    32'(ctrl_a1), 32'(e1.ctrl_a));
            check("div1_ctrl_s",    32'(ctrl_s1), 32'(e1.ctrl_s));
            check("div1_pump_a",    32'(pump_a1), 32'(e1.pump_a));
            check("div1_pump_b",    32'(pump_b1), 32'(e1.pump_b));
            check("div1_busy",      32'(busy1),   32'(e1.busy));
            check("div1_done",      32'(done1),   32'(e1.done));
            check("div1_cmd_ready", 32'(ready1),  32'(e1.ready));
        end
    end

    // kind: 0 normal step, 1 abort during cycle cut_k, 2 reset during cycle cut_k.
    // hold: keep cmd_valid high with different fields until the FINISH cycle.
    task automatic run_step(input logic [12:0] v, input logic [3:0] s, input logic [1:0] en,
                            input int d, input bit hold, input int kind, input int cut_k);
        int   last;
        exp_t e;
        last = (kind == 0) ? SETTLE_CYC + d + 1 : cut_k;
        for (int k = 0; k <= last; k++) begin
            e = exp_at(k, v, s, en, d, PUMP_DIV, prev_a, prev_s);
            if (kind == 2 && k == cut_k) e.ready = 1'b0;
            q0.push_back(e);
            e = exp_at(k, v, s, en, d, 1, prev_a, prev_s);
            if (kind == 2 && k == cut_k) e.ready = 1'b0;
            q1.push_back(e);
        end
        cmd_valid   = 1'b1;
        cmd_valves  = v;
        cmd_sel     = s;
        cmd_pump_en = en;
        cmd_dwell   = 16'(d);
        for (int c = 1; c <= last + 1; c++) begin
            @(posedge clk);
            #1;
            if (c == 1 && hold) begin
                cmd_valves  = ~v;
                cmd_sel     = ~s;
                cmd_pump_en = ~en;
                cmd_dwell   = 16'(d / 2);
            end
            if (!hold || c == last) cmd_valid = 1'b0;
            if (kind == 1 && c == cut_k) abort = 1'b1;
            if (kind == 2 && c == cut_k) rst_n = 1'b0;
            if (kind != 0 && c == cut_k + 1) begin
                abort = 1'b0;
                rst_n = 1'b1;
            end
        end
        prev_a = (kind == 0) ? v : '0;
        prev_s = (kind == 0) ? s : '0;
    endtask

    task automatic idle_abort(input logic [12:0] v, input logic [3:0] s);
        q0.push_back(idle_rec(prev_a, prev_s, 1'b1));
        q1.push_back(idle_rec(prev_a, prev_s, 1'b1));
        q0.push_back(idle_rec('0, '0, 1'b1));
        q1.push_back(idle_rec('0, '0, 1'b1));
        cmd_valid  = 1'b1;
        abort      = 1'b1;
        cmd_valves = v;
        cmd_sel    = s;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        abort     = 1'b0;
        @(posedge clk);
        #1;
        prev_a = '0;
        prev_s = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_valves  = '0;
        cmd_sel     = '0;
        cmd_pump_en = '0;
        cmd_dwell   = '0;
        abort       = 1'b0;
        prev_a      = '0;
        prev_s      = '0;

        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            q0.push_back(idle_rec('0, '0, 1'b0));
            q1.push_back(idle_rec('0, '0, 1'b0));
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;

        run_step(13'h1A5, 4'h3, 2'b01, 12, 1'b0, 0, 0);
        idle_abort(13'h0F0, 4'hC);
        run_step(13'h1A5, 4'h3, 2'b01, 12, 1'b0, 0, 0);
        run_step(13'h0F0, 4'hA, 2'b11, 0,  1'b0, 0, 0);
        run_step(13'h1FFF, 4'hF, 2'b11, 10, 1'b0, 1, SETTLE_CYC + 3);
        run_step(13'h0AA, 4'h5, 2'b01, 6,  1'b1, 0, 0);
        run_step(13'h123, 4'h9, 2'b11, 4,  1'b0, 2, 3);
        run_step(13'h011, 4'h6, 2'b10, 5,  1'b0, 0, 0);
        run_step(13'h1C3, 4'h2, 2'b11, 7,  1'b0, 0, 0);

        for (int i = 0; i < 3; i++) begin
            q0.push_back(idle_rec(prev_a, prev_s, 1'b1));
            q1.push_back(idle_rec(prev_a, prev_s, 1'b1));
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
